// File: rtl/set_bit_scanner.sv
// Walks a captured word and streams the index of each set bit, lowest first,
// over a valid/ready handshake, then pulses done.
module set_bit_scanner #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             done,
  output logic [IDX_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [IDX_W:0]   count_n;
  logic [IDX_W-1:0] lowest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      count  <= count_n;
    end
  end

  // Descending walk so the last hit written is the lowest set bit.
  always_comb begin
    lowest = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (shadow[i-1]) lowest = IDX_W'(i - 1);
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    count_n  = count;
    case (state)
      IDLE: begin
        if (start) begin
          shadow_n = data_in;
          count_n  = '0;
          state_n  = SCAN;
        end
      end
      SCAN: begin
        if (shadow == '0) begin
          state_n = FIN;
        end else if (idx_ready) begin
          // Clear only the lowest set bit; the AND keeps borrow bits out.
          shadow_n = shadow & (shadow - WIDTH'(1));
          count_n  = count + (IDX_W+1)'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign idx_valid = (state == SCAN) && (shadow != '0);
  assign idx       = idx_valid ? lowest : '0;
  assign done      = (state == FIN);

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench for set_bit_scanner; expected indices are queued when a
// word is started and popped as the scanner hands them over.
module tb_set_bit_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;
  logic        busy;
  logic        idx_valid;
  logic        idx_ready = 1'b0;
  logic [4:0]  idx;
  logic        done;
  logic [5:0]  count;

  int passed = 0;
  int total  = 0;
  logic [4:0] q[$];

  set_bit_scanner #(.WIDTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx(idx), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Outputs depend only on registered state, so inputs set at a negedge can be
  // sampled together with outputs at that same negedge.
  task automatic do_scan(input logic [31:0] word, input int stall, input bit inject);
    int  last_acc;
    int  exp_cnt;
    bit  seen_done;
    exp_cnt = $countones(word);
    q.delete();
    for (int i = 0; i < 32; i++) if (word[i]) q.push_back(5'(i));
    @(negedge clk);
    data_in = word; start = 1'b1; idx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; data_in = $urandom;
    last_acc = -1; seen_done = 1'b0;
    chk("count_clear", 32'(count), 32'd0);
    chk("first_valid", 32'(idx_valid), 32'(word != 0));
    for (int c = 0; c < 100 && !seen_done; c++) begin
      idx_ready = (c >= stall);
      if (inject && c == 1) begin
        start = 1'b1; data_in = 32'h00F0_0F00;
      end else begin
        start = 1'b0;
      end
      chk("busy", 32'(busy), 32'd1);
      if (done) begin
        seen_done = 1'b1;
        chk("done_time", 32'(c), 32'(last_acc + 2));
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("count_final", 32'(count), 32'(exp_cnt));
      end else if (idx_valid) begin
        if (q.size() == 0) begin
          chk("extra_valid", 32'(idx_valid), 32'd0);
        end else begin
          chk("idx", 32'(idx), 32'(q[0]));
          if (idx_ready) begin
            void'(q.pop_front());
            last_acc = c;
          end
        end
      end
      if (!seen_done) @(negedge clk);
    end
    if (!seen_done) chk("done_timeout", 32'(seen_done), 32'd1);
    start = 1'b0; idx_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("count_hold", 32'(count), 32'(exp_cnt));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    do_scan(32'h0000_0000, 0, 1'b0);  // T1
    do_scan(32'h8000_0005, 0, 1'b0);  // T2
    do_scan(32'h0000_0012, 3, 1'b0);  // T3
    do_scan(32'hFFFF_FFFF, 0, 1'b0);  // T4
    do_scan(32'h0000_0109, 0, 1'b1);  // T5

    // T6: reset mid-scan after two of three indices
    @(negedge clk);
    data_in = 32'h0000_0106; start = 1'b1; idx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6_idx0", 32'(idx), 32'd1);
    @(negedge clk);
    chk("t6_idx1", 32'(idx), 32'd2);
    @(negedge clk);
    chk("t6_idx2_valid", 32'(idx_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_valid", 32'(idx_valid), 32'd0);
    chk("t6_async_idx", 32'(idx), 32'd0);
    chk("t6_async_done", 32'(done), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    @(negedge clk);
    chk("t6_no_done", 32'(done), 32'd0);
    rst = 1'b0; idx_ready = 1'b0;
    @(negedge clk);
    chk("t6_idle_done", 32'(done), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    do_scan(32'h0000_0002, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
